cnt1s_sched: RTL and testbench

Sequential scheduler for the decimal "count the 1-digits" operation, where the result is the number of decimal digits of the operand equal to 1. Two requesters (A, B) share one iterative digit-scan engine that consumes one decimal digit per clock. A round-robin arbiter picks a requester, latches its operand, runs the scan, and returns the count with a done pulse tagged by requester id. Sits between lab front-end sources and display/compare logic.

---
 rtl/cnt1s_sched.sv | 148 ++++++++++++++
 tb/tb_cnt1s_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt1s_sched.sv
// cnt1s_sched: two-requester scheduler around an iterative engine that counts
// the decimal digits equal to 1 in an operand, one decimal digit per clock.
// A round-robin arbiter grants one requester, latches its operand, scans it
// least-significant digit first and returns the count with a done pulse that
// is tagged with the requester id.
//
// Build option: define CNT1S_SCHED_FIXPRIO_EN for fixed priority (A always
// beats B). In that build the round-robin pointer does not exist.
// Default (macro undefined): round-robin, with A winning the first contention.

module cnt1s_sched #(
    parameter int unsigned W  = 6,  // operand width
    parameter int unsigned CW = 3   // result width, holds the digit count of 2^W-1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [W-1:0]  din_a,
    input  logic          req_b,
    input  logic [W-1:0]  din_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [W-1:0] Ten = W'(10);
    localparam logic [W-1:0] One = W'(1);

    state_e        state_q;
    logic [W-1:0]  aux_q;      // remaining undigested part of the operand
    logic [CW-1:0] cnt_q;      // 1-digits found so far
    logic          id_q;       // requester being served: 0 = A, 1 = B
    logic          gnt_a_q;
    logic          gnt_b_q;
    logic          busy_q;
    logic          done_q;
    logic          done_id_q;
    logic [CW-1:0] o_q;
`ifndef CNT1S_SCHED_FIXPRIO_EN
    logic          rr_last_q;  // last winner: 0 = A, 1 = B
`endif

    logic          win_b_d;    // arbitration result for this edge
    logic [W-1:0]  din_win_d;  // operand of the winner
    logic          aux_ge10_d; // more than one decimal digit left
    logic [W-1:0]  aux_div_d;
    logic [W-1:0]  aux_mod_d;
    logic          digit_one_d;
    logic [CW-1:0] cnt_d;      // count including the digit consumed this step

    // Arbitration: pick the winner among the active requests.
    always_comb begin
        win_b_d = 1'b0;
`ifdef CNT1S_SCHED_FIXPRIO_EN
        win_b_d = req_b && !req_a;
`else
        // On contention the requester that did not win last time goes next.
        win_b_d = req_b && (!req_a || !rr_last_q);
`endif
        din_win_d = win_b_d ? din_b : din_a;
    end

    // Digit step: peel off the lowest decimal digit and test it for 1.
    always_comb begin
        aux_ge10_d  = (aux_q >= Ten);
        aux_div_d   = aux_q / Ten;
        aux_mod_d   = aux_q % Ten;
        // The last (most significant) digit is aux itself once it is below 10.
        digit_one_d = aux_ge10_d ? (aux_mod_d == One) : (aux_q == One);
        cnt_d       = cnt_q + CW'(digit_one_d);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            aux_q     <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            o_q       <= '0;
`ifndef CNT1S_SCHED_FIXPRIO_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_a || req_b) begin
                        aux_q     <= din_win_d;
                        cnt_q     <= '0;
                        id_q      <= win_b_d;
`ifndef CNT1S_SCHED_FIXPRIO_EN
                        rr_last_q <= win_b_d;
`endif
                        gnt_a_q   <= !win_b_d;
                        gnt_b_q   <= win_b_d;
                        busy_q    <= 1'b1;
                        state_q   <= StScan;
                    end
                end
                StScan: begin
                    if (aux_ge10_d) begin
                        cnt_q <= cnt_d;
                        aux_q <= aux_div_d;
                    end else begin
                        o_q       <= cnt_d;
                        done_id_q <= id_q;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign o       = o_q;

endmodule

// File: tb/tb_cnt1s_sched.sv
// Testbench for cnt1s_sched: directed requests with literal expectations plus a
// transaction-level model (decimal string of the operand) compared every cycle.

module tb_cnt1s_sched;

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0;
    logic [W-1:0]  din_a = '0;
    logic          req_b = 1'b0;
    logic [W-1:0]  din_b = '0;
    logic          gnt_a;
    logic          gnt_b;
    logic          busy;
    logic          done;
    logic          done_id;
    logic [CW-1:0] o;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_dones = 0;
    int exp_dones = 0;

    cnt1s_sched #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .din_a   (din_a),
        .req_b   (req_b),
        .din_b   (din_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .o       (o)
    );

    always #5 clk = ~clk;

    // Reference: count '1' characters in the decimal text of v.
    function automatic int ones_ref(input int v);
        string s;
        int c;
        s = $sformatf("%0d", v);
        c = 0;
        for (int i = 0; i < s.len(); i++) if (s[i] == 8'h31) c++;
        return c;
    endfunction

    function automatic int digits_ref(input int v);
        string s;
        s = $sformatf("%0d", v);
        return s.len();
    endfunction

    // Transaction model: a grant occupies the engine for d+1 cycles, done is
    // raised in the last of them.
    int       m_left = 0;
    logic     m_rr = 1'b1;   // last winner, 1 = B
    logic     m_cur = 1'b0;
    int       m_res = 0;
    logic     m_gnt_a = 1'b0, m_gnt_b = 1'b0, m_done = 1'b0, m_id = 1'b0;
    int       m_o = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_rr <= 1'b1; m_cur <= 1'b0; m_res <= 0;
            m_gnt_a <= 1'b0; m_gnt_b <= 1'b0; m_done <= 1'b0; m_id <= 1'b0; m_o <= 0;
        end else begin
            m_gnt_a <= 1'b0;
            m_gnt_b <= 1'b0;
            m_done  <= 1'b0;
            if (m_left == 0) begin
                if (req_a || req_b) begin
                    logic wb;
`ifdef CNT1S_SCHED_FIXPRIO_EN
                    wb = !req_a;
`else
                    wb = (req_a && req_b) ? !m_rr : req_b;
`endif
                    m_cur   <= wb;
                    m_rr    <= wb;
                    m_res   <= ones_ref(int'(wb ? din_b : din_a));
                    m_left  <= digits_ref(int'(wb ? din_b : din_a)) + 1;
                    m_gnt_a <= !wb;
                    m_gnt_b <= wb;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    m_done <= 1'b1;
                    m_o    <= m_res;
                    m_id   <= m_cur;
                end
            end
        end
    end

    // Every-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_left != 0);
        n_tests++;
        if (gnt_a !== m_gnt_a || gnt_b !== m_gnt_b || busy !== m_busy ||
            done !== m_done || done_id !== m_id || int'(o) != m_o) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t act gnt_a=%b gnt_b=%b busy=%b done=%b id=%b o=%0d exp gnt_a=%b gnt_b=%b busy=%b done=%b id=%b o=%0d",
                     $time, gnt_a, gnt_b, busy, done, done_id, o,
                     m_gnt_a, m_gnt_b, m_busy, m_done, m_id, m_o);
        end
        if (done === 1'b1) dut_dones++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // One request with literal expectations: result, and edges from grant to done minus one.
    task automatic do_req(input bit sel_b, input logic [W-1:0] val, input int exp_o,
                          input int exp_d);
        bit ok;
        int waited;
        int n;
        if (sel_b) begin req_b = 1'b1; din_b = val; end
        else begin req_a = 1'b1; din_a = val; end
        ok = 1'b0;
        waited = 0;
        for (int i = 1; i <= 20 && !ok; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin ok = 1'b1; waited = i; end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check("gnt_seen", int'(ok), 1);
        if (ok) begin
            check("gnt_lat", waited, 1);
            check("gnt_who", int'(sel_b ? gnt_b : gnt_a), 1);
            ok = 1'b0;
            n = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                n++;
                if (done) ok = 1'b1;
            end
            check("done_seen", int'(ok), 1);
            check("done_lat", n, exp_d);
            check("o_val", int'(o), exp_o);
            check("done_id", int'(done_id), int'(sel_b));
            exp_dones++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ids[3];
        int os[3];
        int got;
        int exp_id[3];
        int exp_o3[3];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_o", int'(o), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and directed single-requester cases
        do_req(1'b0, 6'd11, 2, 2);
        do_req(1'b0, 6'd0,  0, 1);
        do_req(1'b0, 6'd1,  1, 1);
        do_req(1'b0, 6'd10, 1, 2);
        do_req(1'b0, 6'd41, 1, 2);
        do_req(1'b0, 6'd9,  0, 1);
        do_req(1'b1, 6'd61, 1, 2);

        // Contention from reset: both requesters held high for three rounds
        pulse_reset();
        din_a = 6'd11;
        din_b = 6'd51;
        req_a = 1'b1;
        req_b = 1'b1;
        got = 0;
`ifdef CNT1S_SCHED_FIXPRIO_EN
        exp_id = '{0, 0, 0};
        exp_o3 = '{2, 2, 2};
`else
        exp_id = '{0, 1, 0};
        exp_o3 = '{2, 1, 2};
`endif
        for (int i = 0; i < 60 && got < 3; i++) begin
            @(negedge clk);
            if (done) begin
                ids[got] = int'(done_id);
                os[got]  = int'(o);
                got++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        exp_dones += 3;
        check("rr_rounds", got, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got) begin
                check($sformatf("rr_id%0d", i), ids[i], exp_id[i]);
                check($sformatf("rr_o%0d", i), os[i], exp_o3[i]);
            end
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a scan
        req_a = 1'b1;
        din_a = 6'd31;
        @(negedge clk);
        check("mid_gnt", int'(gnt_a), 1);
        req_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_gnt", int'(gnt_a), 0);
        check("mid_rst_o", int'(o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1, 6'd21, 1, 2);

        // Sweep of the whole operand range
        for (int v = 0; v < 64; v++)
            do_req(1'b0, 6'(v), ones_ref(v), digits_ref(v));

        // Done pulses neither missed nor duplicated
        repeat (2) @(negedge clk);
        check("done_count", dut_dones, exp_dones);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
